// File: rtl/log_mag_expand.sv
// Expands a {exponent, fraction} log code to linear magnitude squared and takes its floor square root.
// One code in flight: IDLE -> EXPAND -> ROOT (MAG_W cycles) -> DONE; results held until out_ready.
module log_mag_expand #(
  parameter int EXP_W  = 6,
  parameter int FRAC_W = 8,
  parameter int SQ_W   = 33,
  parameter int MAG_W  = 17
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W-1:0] in_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SQ_W-1:0]   mag_sqr,
  output logic [MAG_W-1:0]  mag,
  output logic              sat
);

  localparam int RAD_W = 2 * MAG_W;
  localparam int REM_W = MAG_W + 2;
  localparam int CNT_W = $clog2(MAG_W);
  localparam logic [EXP_W-1:0] SQ_LIM   = EXP_W'(SQ_W);
  localparam logic [EXP_W-1:0] FRAC_LIM = EXP_W'(FRAC_W);

  typedef enum logic [1:0] {IDLE, EXPAND, ROOT, DONE} state_t;

  state_t             state_q, state_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [FRAC_W-1:0]  frac_q, frac_d;
  logic [SQ_W-1:0]    sq_q, sq_d;
  logic               sat_int_q, sat_int_d;
  logic [RAD_W-1:0]   rad_q, rad_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [MAG_W-1:0]   root_q, root_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SQ_W-1:0]    mag_sqr_q, mag_sqr_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic               sat_q, sat_d;

  logic [MAG_W+3:0]   rem_sh;
  logic [MAG_W+3:0]   trial;
  logic               take;
  logic [MAG_W-1:0]   root_nx;
  logic [REM_W-1:0]   rem_nx;
  logic [SQ_W-1:0]    sq_exp;
  logic               sat_exp;

  // One restoring root step: bring down the next two radicand bits, try (4*root + 1).
  always_comb begin
    rem_sh  = {rem_q, rad_q[RAD_W-1 -: 2]};
    trial   = {2'b00, root_q, 2'b01};
    take    = (rem_sh >= trial);
    root_nx = {root_q[MAG_W-2:0], take};
    rem_nx  = take ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);
  end

  always_comb begin
    sat_exp = 1'b0;
    sq_exp  = '0;
    if (exp_q >= SQ_LIM) begin
      sat_exp = 1'b1;
      sq_exp  = '1;
    end else if (exp_q < FRAC_LIM) begin
      sq_exp = SQ_W'(frac_q);
    end else begin
      sq_exp = SQ_W'({1'b1, frac_q}) << (exp_q - FRAC_LIM);
    end
  end

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    frac_d    = frac_q;
    sq_d      = sq_q;
    sat_int_d = sat_int_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    cnt_d     = cnt_q;
    mag_sqr_d = mag_sqr_q;
    mag_d     = mag_q;
    sat_d     = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_d   = in_exp;
          frac_d  = in_frac;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        sq_d      = sq_exp;
        sat_int_d = sat_exp;
        rad_d     = RAD_W'(sq_exp);
        rem_d     = '0;
        root_d    = '0;
        cnt_d     = CNT_W'(MAG_W - 1);
        state_d   = ROOT;
      end
      ROOT: begin
        rad_d  = rad_q << 2;
        rem_d  = rem_nx;
        root_d = root_nx;
        cnt_d  = cnt_q - CNT_W'(1);
        // Port registers change only here so partial roots never leak out.
        if (cnt_q == '0) begin
          mag_d     = root_nx;
          mag_sqr_d = sq_q;
          sat_d     = sat_int_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      exp_q     <= '0;
      frac_q    <= '0;
      sq_q      <= '0;
      sat_int_q <= 1'b0;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      mag_sqr_q <= '0;
      mag_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      frac_q    <= frac_d;
      sq_q      <= sq_d;
      sat_int_q <= sat_int_d;
      rad_q     <= rad_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      cnt_q     <= cnt_d;
      mag_sqr_q <= mag_sqr_d;
      mag_q     <= mag_d;
      sat_q     <= sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign mag_sqr   = mag_sqr_q;
  assign mag       = mag_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_log_mag_expand.sv
// Random and directed codes checked against an arithmetic model of expansion and floor sqrt.
module tb_log_mag_expand;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_exp;
  logic [7:0]  in_frac;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] mag_sqr;
  logic [16:0] mag;
  logic        sat;

  int n_chk  = 0;
  int n_pass = 0;

  log_mag_expand dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .in_frac   (in_frac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_sqr   (mag_sqr),
    .mag       (mag),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  function automatic longint ref_sq(input int e, input int f);
    if (e >= 33) return 64'h1_FFFF_FFFF;
    if (e < 8) return longint'(f);
    return longint'(256 + f) << (e - 8);
  endfunction

  // Largest r with r*r <= v.
  function automatic longint ref_root(input longint v);
    longint r = 0;
    for (int b = 16; b >= 0; b--) begin
      longint t = r | (longint'(1) << b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  task automatic check_result(input string tag, input int e, input int f);
    longint s = ref_sq(e, f);
    chk({tag, ".sq"}, mag_sqr, s);
    chk({tag, ".mag"}, mag, ref_root(s));
    chk({tag, ".sat"}, sat, (e >= 33) ? 1 : 0);
  endtask

  // Waits from just after an accept edge until out_valid; returns cycles counted.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send(input string tag, input int e, input int f);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_exp   = 6'(e);
    in_frac  = 8'(f);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    chk({tag, ".lat"}, lat, 19);
    check_result(tag, e, f);
  endtask

  initial begin
    int lat;
    int seen;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_exp    = '0;
    in_frac   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.sq", mag_sqr, 0);
    chk("rst.mag", mag, 0);
    chk("rst.sat", sat, 0);

    send("zero", 0, 8'h00);
    send("small", 5, 8'h25);
    send("e12", 12, 8'h80);
    send("e32", 32, 8'hFF);
    send("sat40", 40, 8'h00);
    send("sat33", 33, 8'h5A);
    send("e7", 7, 8'hFF);
    send("e8", 8, 8'h00);
    send("e63", 63, 8'hFF);

    for (int i = 0; i < 30; i++)
      send("rand", int'($urandom_range(0, 63)), int'($urandom_range(0, 255)));

    // Back-pressure with a second code waiting on in_valid.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_exp    = 6'd12;
    in_frac   = 8'h80;
    @(posedge clk);
    @(negedge clk);
    in_exp  = 6'd9;
    in_frac = 8'h00;
    wait_out(lat);
    chk("bp.lat", lat, 19);
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid", out_valid, 1);
      chk("bp.in_ready", in_ready, 0);
      check_result("bp.hold", 12, 8'h80);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.idle_rdy", in_ready, 1);
    chk("bp.idle_vld", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp2.lat", lat, 19);
    chk("bp2.sq", mag_sqr, 512);
    chk("bp2.mag", mag, 22);
    check_result("bp2", 9, 0);

    // Reset in the middle of a root computation.
    @(negedge clk);
    in_valid = 1'b1;
    in_exp   = 6'd20;
    in_frac  = 8'h03;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid.out_valid", out_valid, 0);
    chk("mid.sq", mag_sqr, 0);
    chk("mid.mag", mag, 0);
    chk("mid.sat", sat, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid.no_result", seen, 0);
    chk("mid.in_ready", in_ready, 1);
    send("after_rst", 20, 8'h03);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
